// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle between the two requesters, the
// arbiter and the single memory port.
//   instr_*  : fetch request (req/addr) and completion (valid/rdata/err)
//   data_*   : load/store request (req/we/addr/wdata/be) and completion
//   mem_*    : memory request (req/we/addr/wdata/be), accept (gnt) and
//              response (rvalid/rdata)
// Modport slave is the arbiter's view; master is the environment's view
// (requesters plus memory).
interface mem_arbiter_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        data_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  instr_req, instr_addr,
        input  data_req, data_we, data_addr, data_wdata, data_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output instr_valid, instr_rdata, instr_err,
        output data_valid, data_rdata, data_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output instr_req, instr_addr,
        output data_req, data_we, data_addr, data_wdata, data_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  instr_valid, instr_rdata, instr_err,
        input  data_valid, data_rdata, data_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the
// load/store path. One transaction outstanding at a time; the winner's
// request is registered onto the memory bus and the response is returned
// to its owner as a one-cycle valid pulse.
// Ports:
//   clk  - clock, all state on rising edge
//   res  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (requester and memory signals)
// Parameters:
//   MaxDataBurst  - data grants allowed while fetch waits (1..15)
//   TimeoutCycles - grant-to-error-completion distance (2..255)
module mem_arbiter #(
    parameter int unsigned MaxDataBurst  = 4,
    parameter int unsigned TimeoutCycles = 16
) (
    input logic          clk,
    input logic          res,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [3:0] BurstMax = 4'(MaxDataBurst);
    // Grant at cycle g, WAIT starts at g+1 with count 0; firing when the
    // count hits TimeoutCycles-2 puts the error response at g+TimeoutCycles.
    localparam logic [7:0] TmoLast  = 8'(TimeoutCycles - 2);

    state_e      state_q;
    logic        fetch_owner_q;
    logic [3:0]  burst_cnt_q;
    logic [7:0]  tmo_cnt_q;

    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic        instr_valid_q, instr_err_q, data_valid_q, data_err_q;
    logic [31:0] instr_rdata_q, data_rdata_q;

    logic        fetch_wins, misaligned;
    logic        rsp_fire, rsp_err;
    logic [31:0] rsp_rdata;

    always_comb begin
        // Data has priority unless fetch has waited out a full burst.
        fetch_wins = bus.instr_req && (!bus.data_req || burst_cnt_q == BurstMax);
        misaligned = bus.instr_addr[1:0] != 2'b00;

        rsp_fire  = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state_q)
            ISSUE: if (bus.mem_gnt && bus.mem_rvalid) begin
                rsp_fire  = 1'b1;
                rsp_rdata = mem_we_q ? 32'h0 : bus.mem_rdata;
            end
            WAIT: if (bus.mem_rvalid) begin
                rsp_fire  = 1'b1;
                rsp_rdata = mem_we_q ? 32'h0 : bus.mem_rdata;
            end else if (tmo_cnt_q == TmoLast) begin
                rsp_fire = 1'b1;
                rsp_err  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= IDLE;
            fetch_owner_q <= 1'b0;
            burst_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            instr_valid_q <= 1'b0;
            instr_err_q   <= 1'b0;
            instr_rdata_q <= '0;
            data_valid_q  <= 1'b0;
            data_err_q    <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            // Response outputs are nonzero only during RESP.
            instr_valid_q <= 1'b0;
            instr_err_q   <= 1'b0;
            instr_rdata_q <= '0;
            data_valid_q  <= 1'b0;
            data_err_q    <= 1'b0;
            data_rdata_q  <= '0;

            case (state_q)
                IDLE: if (bus.instr_req || bus.data_req) begin
                    fetch_owner_q <= fetch_wins;
                    if (fetch_wins) begin
                        burst_cnt_q <= '0;
                        if (misaligned) begin
                            // Never reaches memory; complete with error.
                            instr_valid_q <= 1'b1;
                            instr_err_q   <= 1'b1;
                            state_q       <= RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.instr_addr;
                            mem_wdata_q <= '0;
                            mem_be_q    <= 4'hF;
                            state_q     <= ISSUE;
                        end
                    end else begin
                        burst_cnt_q <= bus.instr_req ? burst_cnt_q + 4'd1 : 4'd0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.data_we;
                        mem_addr_q  <= bus.data_addr;
                        mem_wdata_q <= bus.data_wdata;
                        mem_be_q    <= bus.data_be;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: if (bus.mem_gnt) begin
                    mem_req_q <= 1'b0;
                    tmo_cnt_q <= '0;
                    state_q   <= rsp_fire ? RESP : WAIT;
                end
                WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    if (rsp_fire) state_q <= RESP;
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // rsp_fire only occurs in ISSUE/WAIT, where the owner is settled.
            if (rsp_fire) begin
                if (fetch_owner_q) begin
                    instr_valid_q <= 1'b1;
                    instr_rdata_q <= rsp_rdata;
                    instr_err_q   <= rsp_err;
                end else begin
                    data_valid_q <= 1'b1;
                    data_rdata_q <= rsp_rdata;
                    data_err_q   <= rsp_err;
                end
            end
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_rdata = instr_rdata_q;
    assign bus.instr_err   = instr_err_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.data_rdata  = data_rdata_q;
    assign bus.data_err    = data_err_q;
endmodule
